// File: rtl/resample_cfg_ctrl_pkg.sv
// Shared definitions for the resampler configuration controller:
// settings-bus register offsets, FSM state encoding, configuration record
// and its reset defaults, plus the commit validity rule.
package resample_cfg_ctrl_pkg;

  localparam logic [7:0] OFF_N1     = 8'd0;
  localparam logic [7:0] OFF_N2     = 8'd1;
  localparam logic [7:0] OFF_N3     = 8'd2;
  localparam logic [7:0] OFF_DECIM  = 8'd3;
  localparam logic [7:0] OFF_COMMIT = 8'd4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_EOP,
    ST_HOLD,
    ST_APPLY
  } state_t;

  typedef struct packed {
    logic [15:0] n1;
    logic [15:0] n2;
    logic [15:0] n3;
    logic [15:0] decim;
  } cfg_t;

  localparam cfg_t CFG_RST = '{n1: 16'd1, n2: 16'd0, n3: 16'd0, decim: 16'd0};

  // Either both taps disabled, or n3 strictly below a non-zero n2.
  function automatic logic cfg_valid(input cfg_t c);
    return ((c.n2 == '0) && (c.n3 == '0)) || ((c.n2 != '0) && (c.n3 < c.n2));
  endfunction

endpackage

// File: rtl/resample_cfg_ctrl.sv
// Resampler configuration controller.
// Collects n1/n2/n3/decim through a settings bus into shadow registers and,
// on a commit, waits for the current packet to finish, drains the stream for
// HOLD_CYC cycles, then loads the active configuration while pulsing the
// resampler reset.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   set_stb/set_addr/set_data     settings bus write
//   up_tvalid/up_tlast/up_tready  upstream stream
//   dn_tvalid/dn_tlast/dn_tready  stream toward the resampler (gated)
//   n1/n2/n3/decim                active configuration
//   rs_rst                        resampler reset
//   cfg_busy                      commit in progress
//   cfg_applied                   pulse while the new configuration is loaded
//   cfg_err/err_sticky            rejected write/commit pulse and sticky flag
module resample_cfg_ctrl
  import resample_cfg_ctrl_pkg::*;
#(
  parameter logic [7:0]  SR_BASE  = 8'd128,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        up_tvalid,
  input  logic        up_tlast,
  output logic        up_tready,
  output logic        dn_tvalid,
  output logic        dn_tlast,
  input  logic        dn_tready,
  output logic [15:0] n1,
  output logic [15:0] n2,
  output logic [15:0] n3,
  output logic [15:0] decim,
  output logic        rs_rst,
  output logic        cfg_busy,
  output logic        cfg_applied,
  output logic        cfg_err,
  output logic        err_sticky
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  state_t     state, state_nxt;
  cfg_t       shadow, active;
  logic       in_pkt;
  logic [7:0] hold_cnt;
  logic       g;
  logic       tlast_beat;
  logic [7:0] off;
  logic       in_map;
  logic       commit;
  logic       commit_ok;
  logic       wr_err;
  logic       unused_data_hi;

  assign unused_data_hi = ^set_data[31:16];

  // Gate and pass-through
  assign g          = (state == ST_HOLD) || (state == ST_APPLY);
  assign dn_tvalid  = up_tvalid & ~g;
  assign up_tready  = dn_tready & ~g;
  assign dn_tlast   = up_tlast;
  assign tlast_beat = up_tvalid & up_tready & up_tlast;

  // Settings decode; the offset wraps so any base address works
  assign off       = set_addr - SR_BASE;
  assign in_map    = set_stb && (off <= OFF_COMMIT);
  assign cfg_busy  = (state != ST_RUN);
  assign commit    = in_map && !cfg_busy && (off == OFF_COMMIT);
  assign commit_ok = commit && cfg_valid(shadow);
  assign wr_err    = (in_map && cfg_busy) || (commit && !cfg_valid(shadow));

  assign cfg_applied = (state == ST_APPLY);
  assign rs_rst      = rst | (state == ST_APPLY);

  assign n1    = active.n1;
  assign n2    = active.n2;
  assign n3    = active.n3;
  assign decim = active.decim;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (commit_ok)
          state_nxt = (in_pkt && !tlast_beat) ? ST_WAIT_EOP : ST_HOLD;
      end
      ST_WAIT_EOP: begin
        if (tlast_beat)
          state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST)
          state_nxt = ST_APPLY;
      end
      ST_APPLY: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      in_pkt     <= 1'b0;
      hold_cnt   <= '0;
      shadow     <= CFG_RST;
      active     <= CFG_RST;
      cfg_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;

      if (up_tvalid && up_tready)
        in_pkt <= ~up_tlast;

      // Held at zero outside HOLD, so it starts from 0 on every entry
      hold_cnt <= (state == ST_HOLD) ? hold_cnt + 8'd1 : '0;

      if (in_map && !cfg_busy) begin
        case (off)
          OFF_N1:    shadow.n1    <= set_data[15:0];
          OFF_N2:    shadow.n2    <= set_data[15:0];
          OFF_N3:    shadow.n3    <= set_data[15:0];
          OFF_DECIM: shadow.decim <= set_data[15:0];
          default:   ;
        endcase
      end

      if (state == ST_APPLY)
        active <= shadow;

      cfg_err <= wr_err;

      if (state == ST_APPLY)
        err_sticky <= 1'b0;
      else if (wr_err)
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_resample_cfg_ctrl.sv
// Self-checking bench for resample_cfg_ctrl.
module tb_resample_cfg_ctrl;
  import resample_cfg_ctrl_pkg::*;

  localparam logic [7:0]  BASE = 8'd128;
  localparam int unsigned HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        up_tvalid = 1'b0;
  logic        up_tlast = 1'b0;
  logic        up_tready;
  logic        dn_tvalid;
  logic        dn_tlast;
  logic        dn_tready = 1'b1;
  logic [15:0] n1, n2, n3, decim;
  logic        rs_rst, cfg_busy, cfg_applied, cfg_err, err_sticky;
  logic [63:0] cfg_now;

  int n_cmp = 0;
  int n_err = 0;

  logic        exp_q[$];
  logic        obs_q[$];
  logic [63:0] cfg_q[$];

  always #5 clk = ~clk;

  resample_cfg_ctrl #(.SR_BASE(BASE), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .up_tvalid(up_tvalid), .up_tlast(up_tlast), .up_tready(up_tready),
    .dn_tvalid(dn_tvalid), .dn_tlast(dn_tlast), .dn_tready(dn_tready),
    .n1(n1), .n2(n2), .n3(n3), .decim(decim),
    .rs_rst(rs_rst), .cfg_busy(cfg_busy), .cfg_applied(cfg_applied),
    .cfg_err(cfg_err), .err_sticky(err_sticky)
  );

  assign cfg_now = {n1, n2, n3, decim};

  // Every beat delivered downstream, in order
  always @(posedge clk)
    if (rst === 1'b0 && dn_tvalid === 1'b1 && dn_tready === 1'b1)
      obs_q.push_back(dn_tlast);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [15:0] d);
    set_stb  = 1'b1;
    set_addr = BASE + off;
    set_data = {16'hDEAD, d};
    step();
    set_stb  = 1'b0;
  endtask

  // Measures cycles until cfg_applied; performs no checks itself
  task automatic wait_apply(output int gated, output int open, output bit seen,
                            output logic rs_at);
    gated = 0; open = 0; seen = 0; rs_at = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (cfg_applied === 1'b1) begin
        seen  = 1;
        rs_at = rs_rst;
      end else if (up_tready === 1'b0) gated++;
      else open++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    n_cmp++; if (rs_rst !== 1'b1) begin n_err++; $display("FAIL rst_rs_rst: got %b expected 1", rs_rst); end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cfg_now !== 64'h0001_0000_0000_0000) begin n_err++; $display("FAIL rst_cfg: got %h expected 0001000000000000", cfg_now); end
    n_cmp++; if ({cfg_busy, cfg_applied, cfg_err, err_sticky, rs_rst} !== 5'b0) begin n_err++;
      $display("FAIL rst_flags: got %b expected 00000", {cfg_busy, cfg_applied, cfg_err, err_sticky, rs_rst}); end
    n_cmp++; if (up_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b expected 1", up_tready); end
    step();
  endtask

  task automatic test_idle_commit();
    int gated, open; bit seen; logic rs_at;
    wr(OFF_N1, 16'd3); wr(OFF_N2, 16'd5); wr(OFF_N3, 16'd2);
    @(negedge clk);
    n_cmp++; if (cfg_now !== 64'h0001_0000_0000_0000) begin n_err++; $display("FAIL idle_shadow_only: got %h expected 0001000000000000", cfg_now); end
    step();
    cfg_q.push_back({16'd3, 16'd5, 16'd2, 16'd0});
    set_stb = 1'b1; set_addr = BASE + OFF_COMMIT;
    @(negedge clk);
    n_cmp++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy_at_commit: got %b expected 0", cfg_busy); end
    step();
    set_stb = 1'b0;
    wait_apply(gated, open, seen, rs_at);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL idle_applied: got %b expected 1", seen); end
    n_cmp++; if (gated != HOLD || open != 0) begin n_err++; $display("FAIL idle_hold_cycles: got %0d/%0d expected %0d/0", gated, open, HOLD); end
    n_cmp++; if (rs_at !== 1'b1) begin n_err++; $display("FAIL idle_rs_rst: got %b expected 1", rs_at); end
    @(negedge clk);
    n_cmp++; if (cfg_now !== cfg_q[0]) begin n_err++; $display("FAIL idle_cfg: got %h expected %h", cfg_now, cfg_q[0]); end
    void'(cfg_q.pop_front());
    n_cmp++; if ({cfg_busy, rs_rst, cfg_applied, up_tready} !== 4'b0001) begin n_err++;
      $display("FAIL idle_after: got %b expected 0001", {cfg_busy, rs_rst, cfg_applied, up_tready}); end
    step();
  endtask

  task automatic test_mid_packet();
    int gated, open; bit seen; logic rs_at; int nrdy;
    wr(OFF_N1, 16'd7); wr(OFF_N2, 16'd3); wr(OFF_N3, 16'd1); wr(OFF_DECIM, 16'd2);
    cfg_q.push_back({16'd7, 16'd3, 16'd1, 16'd2});
    exp_q.delete(); obs_q.delete(); nrdy = 0;
    for (int i = 0; i < 32; i++) begin
      up_tvalid = 1'b1;
      up_tlast  = (i == 31);
      set_stb   = (i == 10);
      set_addr  = BASE + OFF_COMMIT;
      exp_q.push_back(up_tlast);
      @(negedge clk);
      if (up_tready !== 1'b1) nrdy++;
      if (i == 11) begin
        n_cmp++; if (cfg_busy !== 1'b1) begin n_err++; $display("FAIL pkt_wait_eop_busy: got %b expected 1", cfg_busy); end
      end
      step();
    end
    up_tvalid = 1'b0; up_tlast = 1'b0; set_stb = 1'b0;
    n_cmp++; if (nrdy != 0) begin n_err++; $display("FAIL pkt_gated_early: got %0d stalled beats expected 0", nrdy); end
    wait_apply(gated, open, seen, rs_at);
    n_cmp++; if (!seen || gated != HOLD || open != 0) begin n_err++;
      $display("FAIL pkt_apply_timing: got seen=%0d gated=%0d open=%0d expected 1/%0d/0", seen, gated, open, HOLD); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL pkt_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL pkt_tlast: got %b expected %b", o, e); end
    end
    @(negedge clk);
    n_cmp++; if (cfg_now !== cfg_q[0]) begin n_err++; $display("FAIL pkt_cfg: got %h expected %h", cfg_now, cfg_q[0]); end
    void'(cfg_q.pop_front());
    step();
  endtask

  task automatic test_tlast_commit();
    int gated, open; bit seen; logic rs_at;
    // Shadow equals active: a same-value commit must still run
    cfg_q.push_back({16'd7, 16'd3, 16'd1, 16'd2});
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      up_tvalid = 1'b1;
      up_tlast  = (i == 3);
      set_stb   = (i == 3);
      set_addr  = BASE + OFF_COMMIT;
      step();
    end
    up_tvalid = 1'b0; up_tlast = 1'b0; set_stb = 1'b0;
    n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL eop_beats: got %0d expected 4", obs_q.size()); end
    wait_apply(gated, open, seen, rs_at);
    n_cmp++; if (!seen || gated != HOLD || open != 0) begin n_err++;
      $display("FAIL eop_direct_hold: got seen=%0d gated=%0d open=%0d expected 1/%0d/0", seen, gated, open, HOLD); end
    @(negedge clk);
    n_cmp++; if (cfg_now !== cfg_q[0]) begin n_err++; $display("FAIL eop_cfg: got %h expected %h", cfg_now, cfg_q[0]); end
    void'(cfg_q.pop_front());
    step();
  endtask

  task automatic test_invalid_commit();
    int gated, open; bit seen; logic rs_at;
    wr(OFF_N2, 16'd4); wr(OFF_N3, 16'd4);
    wr(OFF_COMMIT, 16'd0);
    @(negedge clk);
    n_cmp++; if ({cfg_err, err_sticky, cfg_busy, up_tready} !== 4'b1101) begin n_err++;
      $display("FAIL inv_pulse: got %b expected 1101", {cfg_err, err_sticky, cfg_busy, up_tready}); end
    step();
    @(negedge clk);
    n_cmp++; if ({cfg_err, err_sticky} !== 2'b01) begin n_err++; $display("FAIL inv_sticky: got %b expected 01", {cfg_err, err_sticky}); end
    n_cmp++; if (cfg_now !== {16'd7, 16'd3, 16'd1, 16'd2}) begin n_err++; $display("FAIL inv_cfg_kept: got %h expected 0007000300010002", cfg_now); end
    step();
    // n2 zero with non-zero n3 is also rejected
    wr(OFF_N2, 16'd0);
    wr(OFF_COMMIT, 16'd0);
    @(negedge clk);
    n_cmp++; if ({cfg_err, cfg_busy} !== 2'b10) begin n_err++; $display("FAIL inv_n2_zero: got %b expected 10", {cfg_err, cfg_busy}); end
    step();
    // n3 = n2-1 is the largest legal n3
    wr(OFF_N2, 16'd5);
    cfg_q.push_back({16'd7, 16'd5, 16'd4, 16'd2});
    wr(OFF_COMMIT, 16'd0);
    wait_apply(gated, open, seen, rs_at);
    n_cmp++; if (!seen || gated != HOLD) begin n_err++; $display("FAIL inv_edge_valid: got seen=%0d gated=%0d expected 1/%0d", seen, gated, HOLD); end
    @(negedge clk);
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL inv_sticky_clear: got %b expected 0", err_sticky); end
    n_cmp++; if (cfg_now !== cfg_q[0]) begin n_err++; $display("FAIL inv_edge_cfg: got %h expected %h", cfg_now, cfg_q[0]); end
    void'(cfg_q.pop_front());
    step();
  endtask

  task automatic test_busy_write();
    int gated, open; bit seen; logic rs_at;
    wr(OFF_N1, 16'd9);
    cfg_q.push_back({16'd9, 16'd5, 16'd4, 16'd2});
    set_stb = 1'b1; set_addr = BASE + OFF_COMMIT;
    step();
    set_addr = BASE + OFF_N1; set_data = 32'h0000_0055;
    step();
    set_addr = BASE + 8'd5;
    @(negedge clk);
    n_cmp++; if ({cfg_err, cfg_busy} !== 2'b11) begin n_err++; $display("FAIL busy_wr_err: got %b expected 11", {cfg_err, cfg_busy}); end
    step();
    set_stb = 1'b0;
    @(negedge clk);
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL busy_unmapped: got %b expected 0", cfg_err); end
    step();
    wait_apply(gated, open, seen, rs_at);
    n_cmp++; if (!seen || gated != HOLD - 3) begin n_err++; $display("FAIL busy_apply: got seen=%0d gated=%0d expected 1/%0d", seen, gated, HOLD - 3); end
    @(negedge clk);
    n_cmp++; if (cfg_now !== cfg_q[0]) begin n_err++; $display("FAIL busy_cfg: got %h expected %h", cfg_now, cfg_q[0]); end
    void'(cfg_q.pop_front());
    n_cmp++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL busy_sticky: got %b expected 0", err_sticky); end
    step();
  endtask

  task automatic test_reset_wait_eop();
    int gated, open; bit seen; logic rs_at; int nrdy;
    wr(OFF_N1, 16'd11); wr(OFF_N2, 16'd6); wr(OFF_N3, 16'd5);
    for (int i = 0; i < 3; i++) begin
      up_tvalid = 1'b1; up_tlast = 1'b0;
      set_stb = (i == 2); set_addr = BASE + OFF_COMMIT;
      step();
    end
    up_tvalid = 1'b0; set_stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({cfg_busy, rs_rst} !== 2'b11) begin n_err++; $display("FAIL rwe_in_wait: got %b expected 11", {cfg_busy, rs_rst}); end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cfg_now !== 64'h0001_0000_0000_0000) begin n_err++; $display("FAIL rwe_cfg: got %h expected 0001000000000000", cfg_now); end
    n_cmp++; if ({cfg_busy, err_sticky} !== 2'b00) begin n_err++; $display("FAIL rwe_state: got %b expected 00", {cfg_busy, err_sticky}); end
    step();
    obs_q.delete(); nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      up_tvalid = 1'b1; up_tlast = (i == 5);
      @(negedge clk);
      if (up_tready !== 1'b1 || cfg_applied !== 1'b0) nrdy++;
      step();
    end
    up_tvalid = 1'b0; up_tlast = 1'b0;
    n_cmp++; if (nrdy != 0 || obs_q.size() != 6) begin n_err++;
      $display("FAIL rwe_stream: got stalls=%0d beats=%0d expected 0/6", nrdy, obs_q.size()); end
    // Shadow registers were reset too, so a bare commit applies defaults
    cfg_q.push_back(64'h0001_0000_0000_0000);
    wr(OFF_COMMIT, 16'd0);
    wait_apply(gated, open, seen, rs_at);
    @(negedge clk);
    n_cmp++; if (!seen || cfg_now !== cfg_q[0]) begin n_err++; $display("FAIL rwe_shadow: got seen=%0d cfg=%h expected 1 %h", seen, cfg_now, cfg_q[0]); end
    void'(cfg_q.pop_front());
    step();
  endtask

  initial begin
    test_reset();
    test_idle_commit();
    test_mid_packet();
    test_tlast_commit();
    test_invalid_commit();
    test_busy_write();
    test_reset_wait_eop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/resample_cfg_ctrl.md
RESAMPLE_CFG_CTRL -- requirements
Module: resample_cfg_ctrl

Interface
REQ-001 Parameter SR_BASE, default 8'd128: settings-bus base address.
REQ-002 Parameter HOLD_CYC, default 4: drain cycles before a new configuration is applied; legal range 1..255.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 set_stb  in  1  settings write strobe; set_addr  in  8  address; set_data  in  32  data.
REQ-006 up_tvalid/up_tlast  in  1/1  upstream beat; up_tready  out  1  upstream ready.
REQ-007 dn_tvalid/dn_tlast  out  1/1  beat to the resampler; dn_tready  in  1  resampler ready.
REQ-008 n1, n2, n3, decim  out  16 each  active resampler configuration.
REQ-009 rs_rst  out  1  resampler reset.
REQ-010 cfg_busy  out  1  commit in progress.
REQ-011 cfg_applied  out  1  one-cycle pulse when the new configuration takes effect.
REQ-012 cfg_err  out  1  one-cycle pulse on a rejected commit or write.
REQ-013 err_sticky  out  1  set on any error; cleared by the next accepted commit.

Function
REQ-014 Address map (offset from SR_BASE): +0 n1, +1 n2, +2 n3, +3 decim, all taking set_data[15:0] into shadow registers; +4 commit; any other address is ignored.
REQ-015 Gate signal g is asserted in HOLD and APPLY only.
REQ-016 Pass-through: dn_tvalid = up_tvalid & ~g; up_tready = dn_tready & ~g; dn_tlast = up_tlast; all combinational, zero latency.
REQ-017 Beat: up_tvalid & up_tready. in_pkt is set on a beat with up_tlast=0 and cleared on a beat with up_tlast=1.
REQ-018 A commit is valid only if: (n2==0 and n3==0) or (n2!=0 and n3<n2), evaluated on the shadow values.
REQ-019 FSM states: RUN, WAIT_EOP, HOLD, APPLY; reset state RUN.
REQ-020 RUN, on a valid commit: go to WAIT_EOP if in_pkt=1 and the same cycle has no tlast beat; otherwise go to HOLD.
REQ-021 RUN, on an invalid commit: cfg_err pulses, err_sticky=1, state stays RUN, active values unchanged.
REQ-022 WAIT_EOP: a tlast beat moves the FSM to HOLD on the next cycle; the tlast beat itself passes.
REQ-023 HOLD: an 8-bit counter loads 0 on entry and increments each cycle; at count HOLD_CYC-1 the FSM goes to APPLY.
REQ-024 APPLY lasts exactly one cycle: active registers <= shadow; rs_rst=1; cfg_applied=1; err_sticky cleared; next state RUN.
REQ-025 cfg_busy = (state != RUN).
REQ-026 Any settings write (+0..+4) while cfg_busy=1 is ignored and pulses cfg_err; the shadow registers stay unchanged.
REQ-027 Shadow writes in RUN without a commit never change n1/n2/n3/decim.
REQ-028 rs_rst = rst | (state==APPLY).
REQ-029 A commit writing the same values as the active configuration still executes the full sequence.

Reset
REQ-030 On rst, at the next edge: state=RUN, in_pkt=0, counter=0.
REQ-031 On rst, active and shadow registers: n1=1, n2=0, n3=0, decim=0.
REQ-032 On rst: cfg_applied=0, cfg_err=0, err_sticky=0.
REQ-033 Reset mid-sequence discards the pending commit; the configuration returns to its defaults.

Structure
REQ-034 Shared package holds: register offsets (OFF_N1..OFF_COMMIT), state encoding, and the reset defaults.
REQ-035 No sub-module; one flat FSM with datapath.

Verification
REQ-036 Idle commit n1=3,n2=5,n3=2: HOLD 4 cycles with up_tready=0, then one cycle of rs_rst=1 and cfg_applied=1; outputs read 3/5/2/0 and cfg_busy=0 on the following cycle.
REQ-037 Commit after 10 of 32 packet beats: remaining 22 beats pass, including tlast; gate asserts the cycle after tlast; apply 5 cycles later.
REQ-038 Commit in the same cycle as a tlast beat: FSM goes directly to HOLD; WAIT_EOP never entered.
REQ-039 Invalid commit n2=4,n3=4: cfg_err pulse, err_sticky=1, no gating; a later valid commit clears err_sticky at APPLY.
REQ-040 Write to +0 during HOLD: cfg_err pulse; the applied n1 equals the pre-HOLD shadow value.
REQ-041 rst asserted in WAIT_EOP: outputs return to 1/0/0/0; state RUN; streaming continues ungated.
